// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// op codes, controller state encoding and op legality check.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASB = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} share_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASB, OP_NOR: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; unsupported op codes yield zero.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [3:0]   i_op,
  output logic [N-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_PASB: o_result = i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Starting at 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_last_grant <= 1'b1;
    else if (i_advance && (o_grant != 2'b00))
      r_last_grant <= o_grant[1];
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters: arbitrate, latch operands,
// execute, then hold the result until the owning requester takes it.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic              busy
);

  share_state_t r_state, w_next;
  logic [N-1:0] r_a, r_b, r_result;
  logic [3:0]   r_op;
  logic         r_owner, r_zero, r_illegal;
  logic [1:0]   w_grant;
  logic [N-1:0] w_alu_result;
  logic         w_idle, w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (w_grant != 2'b00);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req_valid),
    .i_advance (w_idle),
    .o_grant   (w_grant)
  );

  alu #(.N(N)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result)
  );

  // Grant is gated by reset so req_ready drops the instant reset asserts.
  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      IDLE: begin
        if (!reset) req_ready = w_grant;
        if (w_grant != 2'b00) w_next = EXEC;
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready[r_owner]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_owner   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant[1];
        r_a     <= w_grant[1] ? req_a[2*N-1:N] : req_a[N-1:0];
        r_b     <= w_grant[1] ? req_b[2*N-1:N] : req_b[N-1:0];
        r_op    <= w_grant[1] ? req_op[7:4]    : req_op[3:0];
      end
      if (r_state == EXEC) begin
        r_result  <= w_alu_result;
        r_zero    <= (w_alu_result == '0);
        r_illegal <= !is_legal_op(r_op);
      end
    end
  end

  assign rsp_valid   = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result  = r_result;
  assign rsp_zero    = r_zero;
  assign rsp_illegal = r_illegal;
  assign busy        = !w_idle;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed-vector bench for alu_share_ctrl with a transaction-level reference model.
module tb_alu_share_ctrl;
  localparam int N = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] req_a, req_b;
  logic [7:0]     req_op;
  logic [N-1:0]   rsp_result;
  logic           rsp_zero, rsp_illegal, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.N(N), .NREQ(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference ALU: bit N flags an unsupported op code.
  function automatic logic [N:0] model_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0:    return {1'b0, a & b};
      4'd1:    return {1'b0, a | b};
      4'd2:    return {1'b0, a + b};
      4'd6:    return {1'b0, a - b};
      4'd7:    return {1'b0, b};
      4'd12:   return {1'b0, ~(a | b)};
      default: return {1'b1, {N{1'b0}}};
    endcase
  endfunction

  // Transaction model: phase = edges since acceptance (0 = free, 1 = computing, 2 = holding).
  int           m_phase = 0;
  int           m_owner = 0;
  bit           m_last_was1 = 1'b1;
  logic [N-1:0] m_res = '0;
  bit           m_ill = 1'b0;

  function automatic logic [1:0] exp_ready();
    if (reset || m_phase != 0) return 2'b00;
    if (req_valid == 2'b11)    return m_last_was1 ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [1:0] g;
    logic [N:0] r;
    if (reset) begin
      m_phase     = 0;
      m_last_was1 = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          g = exp_ready();
          if (g != 2'b00) begin
            m_owner     = g[1] ? 1 : 0;
            m_last_was1 = g[1];
            r           = model_alu(req_a[m_owner*N +: N], req_b[m_owner*N +: N],
                                    req_op[m_owner*4 +: 4]);
            m_ill       = r[N];
            m_res       = r[N-1:0];
            m_phase     = 1;
          end
        end
        1:       m_phase = 2;
        default: if (rsp_ready[m_owner]) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_req_ready", 64'(req_ready), 64'(exp_ready()));
      check("cmp_rsp_valid", 64'(rsp_valid),
            64'((m_phase == 2) ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00));
      check("cmp_busy", 64'(busy), 64'(m_phase != 0));
      if (m_phase == 2) begin
        check("cmp_result",  rsp_result,        m_res);
        check("cmp_zero",    64'(rsp_zero),     64'(m_res == '0));
        check("cmp_illegal", 64'(rsp_illegal),  64'(m_ill));
      end
    end
  end

  task automatic drive(input int i, input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [3:0] op);
    req_valid[i]       = v;
    req_a[i*N +: N]    = a;
    req_b[i*N +: N]    = b;
    req_op[i*4 +: 4]   = op;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input int idx, input int budget, input string name);
    int n = 0;
    while (!rsp_valid[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(rsp_valid[idx]), 64'd1);
  endtask

  // Single op on an idle block with only this requester valid.
  task automatic run_one(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] op, input logic [N-1:0] exp_res,
                         input bit exp_zero, input bit exp_ill, input string name);
    drive(i, 1'b1, a, b, op);
    step();
    drive(i, 1'b0, '0, '0, 4'd0);
    wait_rsp(i, 8, {name, "_timeout"});
    check({name, "_result"},  rsp_result,        exp_res);
    check({name, "_zero"},    64'(rsp_zero),     64'(exp_zero));
    check({name, "_illegal"}, 64'(rsp_illegal),  64'(exp_ill));
    step();
  endtask

  int grant_idx[4];
  int grant_cyc[4];
  int ng;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b11;
    #1;
    check("rst_req_ready", 64'(req_ready),   64'd0);
    check("rst_rsp_valid", 64'(rsp_valid),   64'd0);
    check("rst_busy",      64'(busy),        64'd0);
    check("rst_result",    rsp_result,       64'd0);
    check("rst_zero",      64'(rsp_zero),    64'd0);
    check("rst_illegal",   64'(rsp_illegal), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step();

    // Single request: ready in the same cycle, response after two edges.
    drive(0, 1'b1, 64'd5, 64'd3, 4'b0010);
    @(negedge clk);
    check("t1_ready_same_cycle", 64'(req_ready), 64'h1);
    step();
    drive(0, 1'b0, '0, '0, 4'd0);
    @(negedge clk);
    check("t1_rsp_not_yet", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_result",    rsp_result,     64'd8);
    check("t1_zero",      64'(rsp_zero),  64'd0);
    step();
    step();

    // Zero flag, requester 1.
    drive(1, 1'b1, 64'd7, 64'd7, 4'b0110);
    step();
    drive(1, 1'b0, '0, '0, 4'd0);
    wait_rsp(1, 8, "t2_timeout");
    check("t2_rsp_valid", 64'(rsp_valid), 64'h2);
    check("t2_result",    rsp_result,     64'd0);
    check("t2_zero",      64'(rsp_zero),  64'd1);
    step();
    step();

    // Tie fairness with continuous requests.
    drive(0, 1'b1, 64'd10, 64'd20, 4'b0010);
    drive(1, 1'b1, 64'd9,  64'd4,  4'b0110);
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && ng < 4) begin
        grant_idx[ng] = req_ready[1] ? 1 : 0;
        grant_cyc[ng] = c;
        ng++;
      end
    end
    check("t3_grant_count", 64'(ng), 64'd4);
    check("t3_grant0", 64'(grant_idx[0]), 64'd0);
    check("t3_grant1", 64'(grant_idx[1]), 64'd1);
    check("t3_grant2", 64'(grant_idx[2]), 64'd0);
    check("t3_grant3", 64'(grant_idx[3]), 64'd1);
    check("t3_spacing1", 64'(grant_cyc[1] - grant_cyc[0]), 64'd3);
    check("t3_spacing3", 64'(grant_cyc[3] - grant_cyc[2]), 64'd3);
    step();
    drive(0, 1'b0, '0, '0, 4'd0);
    drive(1, 1'b0, '0, '0, 4'd0);
    step();
    step();
    step();

    // Backpressure on owner 0 while the non-owner says ready and also requests.
    rsp_ready = 2'b10;
    drive(0, 1'b1, 64'hFF00, 64'h0F0F, 4'b0001);
    drive(1, 1'b1, 64'd3,    64'd2,    4'b0000);
    @(negedge clk);
    check("t4_ready_r0", 64'(req_ready), 64'h1);
    step();
    drive(0, 1'b0, '0, '0, 4'd0);
    wait_rsp(0, 8, "t4_timeout");
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid",  64'(rsp_valid), 64'h1);
      check("t4_hold_result", rsp_result,     64'hFF0F);
      check("t4_hold_ready",  64'(req_ready), 64'h0);
      check("t4_hold_busy",   64'(busy),      64'd1);
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    wait_rsp(1, 8, "t4_r1_timeout");
    check("t4_r1_result", rsp_result, 64'd2);
    drive(1, 1'b0, '0, '0, 4'd0);
    step();
    step();

    // Illegal op and boundary values.
    run_one(0, 64'd1, 64'd1, 4'b0011, 64'd0, 1'b1, 1'b1, "t5_illegal");
    run_one(0, 64'd0, 64'd0, 4'b1100, {N{1'b1}}, 1'b0, 1'b0, "t5_nor");
    run_one(1, {N{1'b1}}, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0, "t5_add_wrap");
    run_one(1, 64'd0, 64'd1, 4'b0110, {N{1'b1}}, 1'b0, 1'b0, "t5_sub_wrap");
    run_one(0, 64'hF0F0, 64'h3C3C, 4'b0000, 64'h3030, 1'b0, 1'b0, "t5_and");
    run_one(1, 64'd11, 64'hABCD, 4'b0111, 64'hABCD, 1'b0, 1'b0, "t5_passb");

    // Asynchronous reset in the middle of an operation.
    drive(0, 1'b1, 64'd100, 64'd1, 4'b0010);
    drive(1, 1'b1, 64'd50,  64'd5, 4'b0110);
    step();
    #1;
    reset = 1'b1;
    #1;
    check("t6_req_ready", 64'(req_ready),   64'd0);
    check("t6_rsp_valid", 64'(rsp_valid),   64'd0);
    check("t6_busy",      64'(busy),        64'd0);
    check("t6_result",    rsp_result,       64'd0);
    check("t6_zero",      64'(rsp_zero),    64'd0);
    check("t6_illegal",   64'(rsp_illegal), 64'd0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    check("t6_first_tie_r0", 64'(req_ready), 64'h1);
    step();
    drive(0, 1'b0, '0, '0, 4'd0);
    drive(1, 1'b0, '0, '0, 4'd0);
    wait_rsp(0, 8, "t6_timeout");
    check("t6_result_after", rsp_result, 64'd101);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
